time_src_sched: RTL and testbench

TIME_SRC_SCHED -- requirements
Module: time_src_sched

---
 rtl/time_src_sched.sv | 195 +++++++++++++++++++
 tb/tb_time_src_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_src_sched.sv
// Time-source scheduler: qualifies IRIG-B seconds, falls back to holdover, free-run or remote
// time, and emits single-cycle load strobes for a downstream second counter.
module time_src_sched #(
  parameter int CLK_HZ      = 125000000,
  parameter int PPS_TIMEOUT = 137500000,
  parameter int LOCK_CNT    = 3,
  parameter int HOLD_MAX    = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irig_pps,
  input  logic        irig_sec_valid,
  input  logic [31:0] irig_sec,
  input  logic        rm_time_valid,
  input  logic [31:0] rm_time,
  input  logic [1:0]  cfg_mode,
  output logic        load_valid,
  output logic [31:0] load_sec,
  output logic [1:0]  state_o,
  output logic        lock_o,
  output logic [7:0]  hold_sec_o
);

  // Handshake: irig_sec_valid, rm_time_valid and load_valid are one-cycle strobes with no
  // back-pressure; the data beside a strobe is only meaningful in the cycle it is high.

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int WD_W  = $clog2(PPS_TIMEOUT + 1);
  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(PPS_TIMEOUT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [2:0]       LOCK_C   = 3'(LOCK_CNT);
  localparam logic [7:0]       HOLD_C   = 8'(HOLD_MAX);

  state_t            state;
  state_t            state_next;
  logic              pps_q;
  logic              pe;
  logic [WD_W-1:0]   wd;
  logic              irig_lost;
  logic [31:0]       prev_sec;
  logic [2:0]        cc;
  logic [2:0]        cc_next;
  logic              sec_consistent;
  logic              lock_hit;
  logic [DIV_W-1:0]  div;
  logic [7:0]        hold_sec;
  logic              irig_load;
  logic              rm_ok;
  logic              rm_load;

  // PPS edge detect, registered so pe lands on the cycle after the rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pps_q <= 1'b0;
      pe    <= 1'b0;
    end else begin
      pps_q <= irig_pps;
      pe    <= irig_pps & ~pps_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= '0;
    end else if (pe) begin
      wd <= '0;
    end else if (wd != WD_MAX) begin
      wd <= wd + 1'b1;
    end
  end

  assign irig_lost      = (wd == WD_MAX);
  assign sec_consistent = (irig_sec == prev_sec + 32'd1);

  always_comb begin
    cc_next = cc;
    if (cfg_mode[1] || irig_lost) begin
      cc_next = 3'd0;
    end else if (irig_sec_valid) begin
      if (sec_consistent) begin
        cc_next = (cc == LOCK_C) ? cc : cc + 3'd1;
      end else begin
        cc_next = 3'd1;
      end
    end
  end

  assign lock_hit = irig_sec_valid && sec_consistent && (cc_next == LOCK_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc       <= 3'd0;
      prev_sec <= 32'd0;
    end else begin
      cc <= cc_next;
      if (irig_sec_valid) begin
        prev_sec <= irig_sec;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FREE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next-state logic; loss of PPS outranks a coincident strobe.
  always_comb begin
    state_next = state;
    if (cfg_mode[1]) begin
      state_next = ST_FREE;
    end else begin
      case (state)
        ST_FREE: begin
          if (irig_sec_valid) state_next = ST_QUAL;
        end
        ST_QUAL: begin
          if (irig_lost)     state_next = ST_FREE;
          else if (lock_hit) state_next = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (irig_lost)                             state_next = ST_HOLD;
          else if (irig_sec_valid && !sec_consistent) state_next = ST_QUAL;
        end
        ST_HOLD: begin
          if (irig_sec_valid)         state_next = ST_QUAL;
          else if (hold_sec == HOLD_C) state_next = ST_FREE;
        end
        default: state_next = ST_FREE;
      endcase
    end
  end

  // FSM: outputs and load arbitration (IRIG wins a same-cycle collision).
  always_comb begin
    lock_o    = (state == ST_LOCKED);
    irig_load = 1'b0;
    rm_ok     = 1'b0;
    if (!cfg_mode[1] && !irig_lost && irig_sec_valid && sec_consistent) begin
      irig_load = (state == ST_LOCKED) || ((state == ST_QUAL) && (cc_next == LOCK_C));
    end
    if (cfg_mode == 2'd2) begin
      rm_ok = 1'b1;
    end else if (cfg_mode == 2'd0) begin
      rm_ok = (state == ST_FREE) || (state == ST_HOLD);
    end
    rm_load = rm_time_valid && rm_ok && !irig_load;
  end

  assign state_o    = state;
  assign hold_sec_o = hold_sec;

  // Holdover second counter; cleared on the entry edge and on the exit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      hold_sec <= 8'd0;
    end else if (state != ST_HOLD || state_next != ST_HOLD) begin
      div      <= '0;
      hold_sec <= 8'd0;
    end else if (div == DIV_LAST) begin
      div      <= '0;
      hold_sec <= (hold_sec == 8'hFF) ? hold_sec : hold_sec + 8'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_valid <= 1'b0;
      load_sec   <= 32'd0;
    end else begin
      load_valid <= irig_load | rm_load;
      if (irig_load) begin
        load_sec <= irig_sec;
      end else if (rm_load) begin
        load_sec <= rm_time;
      end
    end
  end

endmodule

// File: tb/tb_time_src_sched.sv
// Directed bench for time_src_sched: lock, discontinuity, holdover, remote fallback,
// collision and reset scenarios with hand-computed expectations.
module tb_time_src_sched;

  localparam int CLK_HZ      = 100;
  localparam int PPS_TIMEOUT = 1000;
  localparam int LOCK_CNT    = 3;
  localparam int HOLD_MAX    = 4;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_QUAL   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irig_pps = 1'b0;
  logic        irig_sec_valid = 1'b0;
  logic [31:0] irig_sec = 32'd0;
  logic        rm_time_valid = 1'b0;
  logic [31:0] rm_time = 32'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        load_valid;
  logic [31:0] load_sec;
  logic [1:0]  state_o;
  logic        lock_o;
  logic [7:0]  hold_sec_o;

  int errors = 0;
  int checks = 0;

  time_src_sched #(
    .CLK_HZ(CLK_HZ), .PPS_TIMEOUT(PPS_TIMEOUT), .LOCK_CNT(LOCK_CNT), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk(clk), .rst(rst), .irig_pps(irig_pps), .irig_sec_valid(irig_sec_valid),
    .irig_sec(irig_sec), .rm_time_valid(rm_time_valid), .rm_time(rm_time),
    .cfg_mode(cfg_mode), .load_valid(load_valid), .load_sec(load_sec),
    .state_o(state_o), .lock_o(lock_o), .hold_sec_o(hold_sec_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pps_pulse();
    irig_pps = 1'b1;
    @(negedge clk);
    irig_pps = 1'b0;
  endtask

  task automatic sec_strobe(input logic [31:0] s);
    irig_sec = s;
    irig_sec_valid = 1'b1;
    @(negedge clk);
    irig_sec_valid = 1'b0;
  endtask

  task automatic rm_strobe(input logic [31:0] t);
    rm_time = t;
    rm_time_valid = 1'b1;
    @(negedge clk);
    rm_time_valid = 1'b0;
  endtask

  // One 500-cycle IRIG second: PPS, strobe 10 cycles later, then idle.
  task automatic second(input logic [31:0] s, input logic exp_load, input logic [1:0] exp_state);
    pps_pulse();
    cyc(10);
    sec_strobe(s);
    chk($sformatf("sec%0d_state", s), state_o, exp_state);
    chk($sformatf("sec%0d_lock", s), lock_o, (exp_state == S_LOCKED));
    chk($sformatf("sec%0d_load_valid", s), load_valid, exp_load);
    if (exp_load) chk($sformatf("sec%0d_load_sec", s), load_sec, s);
    cyc(1);
    chk($sformatf("sec%0d_load_once", s), load_valid, 1'b0);
    cyc(487);
  endtask

  // Last PPS edge E0; pe is high after E0, watchdog hits 1000 after E1001, HOLD after E1002.
  task automatic wait_hold();
    int n;
    pps_pulse();
    n = 0;
    while (state_o !== S_HOLD && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_entry_cycles", n, 1002);
    chk("hold_entry_lock", lock_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout state=%0d", state_o);
    $fatal(1, "simulation time limit");
  end

  initial begin
    cyc(3);
    chk("rst_state", state_o, S_FREE);
    chk("rst_load_valid", load_valid, 1'b0);
    chk("rst_load_sec", load_sec, 32'd0);
    chk("rst_lock", lock_o, 1'b0);
    chk("rst_hold", hold_sec_o, 8'd0);
    rst = 1'b0;
    cyc(2);

    // Lock: 100 is inconsistent with prev 0 (cc=1), 101 -> 2, 102 -> 3 locks and loads.
    second(32'd100, 1'b0, S_QUAL);
    second(32'd101, 1'b0, S_QUAL);
    second(32'd102, 1'b1, S_LOCKED);

    // Discontinuity.
    second(32'd103, 1'b1, S_LOCKED);
    second(32'd200, 1'b0, S_QUAL);
    chk("disc_cc", dut.cc, 3'd1);
    second(32'd201, 1'b0, S_QUAL);
    second(32'd202, 1'b1, S_LOCKED);

    // Holdover: seconds at 100-cycle spacing, FREE one cycle after reaching 4.
    wait_hold();
    chk("hold_start", hold_sec_o, 8'd0);
    for (int k = 1; k <= HOLD_MAX; k++) begin
      cyc(99);
      chk($sformatf("hold_pre%0d", k), hold_sec_o, k - 1);
      cyc(1);
      chk($sformatf("hold_sec%0d", k), hold_sec_o, k);
      chk($sformatf("hold_state%0d", k), state_o, S_HOLD);
    end
    cyc(1);
    chk("hold_exit_state", state_o, S_FREE);
    chk("hold_exit_sec", hold_sec_o, 8'd0);
    chk("hold_exit_noload", load_valid, 1'b0);

    // Remote fallback in FREE.
    rm_strobe(32'd5000);
    chk("rm_free_valid", load_valid, 1'b1);
    chk("rm_free_sec", load_sec, 32'd5000);
    chk("rm_free_state", state_o, S_FREE);
    cyc(1);
    chk("rm_free_once", load_valid, 1'b0);
    chk("rm_free_held", load_sec, 32'd5000);

    second(32'd300, 1'b0, S_QUAL);
    second(32'd301, 1'b0, S_QUAL);
    second(32'd302, 1'b1, S_LOCKED);

    // Remote ignored in LOCKED (mode 0) and in mode 1.
    rm_strobe(32'd6000);
    chk("rm_locked_noload", load_valid, 1'b0);
    chk("rm_locked_state", state_o, S_LOCKED);
    cfg_mode = 2'd1;
    rm_strobe(32'd6001);
    chk("rm_mode1_noload", load_valid, 1'b0);
    chk("rm_mode1_sec", load_sec, 32'd302);
    second(32'd303, 1'b1, S_LOCKED);
    cfg_mode = 2'd0;

    // Collision with mode switch to 2: forced FREE, remote load wins.
    pps_pulse();
    cyc(10);
    cfg_mode = 2'd2;
    irig_sec = 32'd304;
    irig_sec_valid = 1'b1;
    rm_time = 32'd7000;
    rm_time_valid = 1'b1;
    @(negedge clk);
    irig_sec_valid = 1'b0;
    rm_time_valid = 1'b0;
    chk("col2_state", state_o, S_FREE);
    chk("col2_lock", lock_o, 1'b0);
    chk("col2_valid", load_valid, 1'b1);
    chk("col2_sec", load_sec, 32'd7000);
    chk("col2_cc", dut.cc, 3'd0);
    cyc(1);
    chk("col2_once", load_valid, 1'b0);
    cfg_mode = 2'd0;
    cyc(480);

    second(32'd305, 1'b0, S_QUAL);
    second(32'd306, 1'b0, S_QUAL);
    second(32'd307, 1'b1, S_LOCKED);

    // Collision in HOLD (mode 0): QUAL entered, remote load issued.
    wait_hold();
    pps_pulse();
    cyc(3);
    irig_sec = 32'd400;
    irig_sec_valid = 1'b1;
    rm_time = 32'd8000;
    rm_time_valid = 1'b1;
    @(negedge clk);
    irig_sec_valid = 1'b0;
    rm_time_valid = 1'b0;
    chk("colh_state", state_o, S_QUAL);
    chk("colh_valid", load_valid, 1'b1);
    chk("colh_sec", load_sec, 32'd8000);
    chk("colh_hold", hold_sec_o, 8'd0);
    chk("colh_cc", dut.cc, 3'd1);
    cyc(1);
    chk("colh_once", load_valid, 1'b0);
    cyc(480);

    second(32'd401, 1'b0, S_QUAL);
    second(32'd402, 1'b1, S_LOCKED);

    // Reset right after a consistent LOCKED strobe.
    pps_pulse();
    cyc(10);
    sec_strobe(32'd403);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", load_valid, 1'b0);
    chk("rstmid_sec", load_sec, 32'd0);
    chk("rstmid_state", state_o, S_FREE);
    chk("rstmid_lock", lock_o, 1'b0);
    chk("rstmid_hold", hold_sec_o, 8'd0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("rstpost_valid", load_valid, 1'b0);
    chk("rstpost_state", state_o, S_FREE);
    chk("rstpost_cc", dut.cc, 3'd0);

    // Mode gating of the remote strobe in FREE.
    cfg_mode = 2'd3;
    rm_strobe(32'd9000);
    chk("rm_mode3_noload", load_valid, 1'b0);
    cfg_mode = 2'd1;
    rm_strobe(32'd9001);
    chk("rm_mode1f_noload", load_valid, 1'b0);
    cfg_mode = 2'd2;
    rm_strobe(32'd9002);
    chk("rm_mode2_valid", load_valid, 1'b1);
    chk("rm_mode2_sec", load_sec, 32'd9002);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
